// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide sequencer for the EX stage.
// Accepts one md op per start pulse. mult/div ops hold busy for a fixed
// latency and then commit HI/LO. mthi/mtlo write HI or LO at the accepting edge.
// Ports:
//   clk, reset (async, active-low)
//   start, md_op[2:0], rs_data[31:0], rt_data[31:0]  - EX-stage md request
//   busy  - mult/div in flight
//   done  - one-cycle pulse after the HI/LO commit of a mult/div
//   hi, lo - architectural HI/LO registers
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW = 32;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic            done_q, done_d;

  // Result datapath, driven from the latched operands
  logic [2*DW-1:0] prod_s, prod_u;
  logic            a_neg, b_neg;
  logic [DW-1:0]   a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [DW-1:0]   sq, sr, uq, ur;
  logic [DW-1:0]   res_hi, res_lo;
  logic            res_wr;

  // Signed divide done on magnitudes so that 0x80000000 / -1 wraps cleanly
  always_comb begin
    prod_s     = $signed({{DW{a_q[DW-1]}}, a_q}) * $signed({{DW{b_q[DW-1]}}, b_q});
    prod_u     = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
    a_neg      = a_q[DW-1];
    b_neg      = b_q[DW-1];
    a_mag      = a_neg ? DW'(~a_q + 32'd1) : a_q;
    b_mag      = b_neg ? DW'(~b_q + 32'd1) : b_q;
    b_mag_safe = (b_mag == '0) ? 32'd1 : b_mag;
    b_u_safe   = (b_q == '0) ? 32'd1 : b_q;
    sq         = a_mag / b_mag_safe;
    sr         = a_mag % b_mag_safe;
    uq         = a_q / b_u_safe;
    ur         = a_q % b_u_safe;
    res_hi     = hi_q;
    res_lo     = lo_q;
    res_wr     = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[2*DW-1:DW];
        res_lo = prod_s[DW-1:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[2*DW-1:DW];
        res_lo = prod_u[DW-1:0];
        res_wr = 1'b1;
      end
      OP_DIV: begin
        res_lo = (a_neg ^ b_neg) ? DW'(~sq + 32'd1) : sq;
        res_hi = a_neg ? DW'(~sr + 32'd1) : sr;
        res_wr = (b_q != '0);
      end
      OP_DIVU: begin
        res_lo = uq;
        res_hi = ur;
        res_wr = (b_q != '0);
      end
      default: ;
    endcase
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              op_d    = md_op;
              a_d     = rs_data;
              b_d     = rt_data;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = md_op;
              a_d     = rs_data;
              b_d     = rt_data;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // start is ignored here; the hazard unit keeps it from happening
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one mult/div op at the current negedge and follow it to the done cycle.
  // Optionally fires a multu request in the second busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] new_hi, input logic [31:0] new_lo,
                        input bit inject);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (inject && i == 1) begin
        start = 1'b1; md_op = 3'd2; rs_data = 32'd5; rt_data = 32'd7;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
      chk({tag, "_busy"},   32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_hold_hi"}, hi, old_hi);
      chk({tag, "_hold_lo"}, lo, old_lo);
      @(negedge clk);
    end
    start = 1'b0; md_op = 3'd0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hi"},   hi, new_hi);
    chk({tag, "_lo"},   lo, new_lo);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_data = '0; rt_data = '0;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_hi", hi, 32'd0);
      chk("idle_lo", lo, 32'd0);
    end

    // mult -2 * 3
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    @(negedge clk);
    chk("mult_done_drop", 32'(done), 32'd0);
    chk("mult_hi_keep", hi, 32'hFFFF_FFFF);

    // divu 7/2, then div -7/2 issued in the done cycle
    run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
           32'd1, 32'd3, 1'b0);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'd3,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    chk("div_done_drop", 32'(done), 32'd0);

    // mthi / mtlo
    start = 1'b1; md_op = 3'd5; rs_data = 32'h11;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_lo", lo, 32'hFFFF_FFFD);
    chk("mthi_busy", 32'(busy), 32'd0);
    start = 1'b1; md_op = 3'd6; rs_data = 32'h22;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    chk("mtlo_lo", lo, 32'h22);
    chk("mtlo_hi", hi, 32'h11);
    chk("mtlo_busy", 32'(busy), 32'd0);

    // md_op 0 and 7 with start do nothing
    start = 1'b1; md_op = 3'd7; rs_data = 32'h99;
    @(negedge clk);
    md_op = 3'd0;
    @(negedge clk);
    start = 1'b0;
    chk("rsv_busy", 32'(busy), 32'd0);
    chk("rsv_hi", hi, 32'h11);
    chk("rsv_lo", lo, 32'h22);

    // Divide by zero keeps HI/LO, signed overflow wraps
    run_op("div0", 3'd3, 32'd1234, 32'd0, 10, 32'h11, 32'h22,
           32'h11, 32'h22, 1'b0);
    @(negedge clk);
    run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h11, 32'h22,
           32'd0, 32'h8000_0000, 1'b0);
    @(negedge clk);

    // mthi 0xDEADBEEF
    start = 1'b1; md_op = 3'd5; rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    chk("mthi2_hi", hi, 32'hDEAD_BEEF);
    chk("mthi2_lo", lo, 32'h8000_0000);
    chk("mthi2_busy", 32'(busy), 32'd0);

    // divu 100/7 with a stray multu start mid-flight
    run_op("ignore", 3'd4, 32'd100, 32'd7, 10, 32'hDEAD_BEEF, 32'h8000_0000,
           32'd2, 32'd14, 1'b1);
    @(negedge clk);
    chk("ignore_no_restart", 32'(busy), 32'd0);

    // Wide products
    run_op("multu_big", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd2, 32'd14,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_big", 3'd1, 32'h8000_0000, 32'h8000_0000, 5,
           32'hFFFF_FFFE, 32'h0000_0001, 32'h4000_0000, 32'd0, 1'b0);
    @(negedge clk);

    // Mid-op reset aborts the operation
    start = 1'b1; md_op = 3'd1; rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_busy", 32'(busy), 32'd0);
      chk("post_abort_hi", hi, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the HI/LO multiply/divide resource in the EX stage of the 5-stage MIPS pipeline.
- Accepts one md operation per start pulse (mult, multu, div, divu, mthi, mtlo) and holds `busy` for a fixed per-operation latency.
- Commits results into the HI/LO registers, which mfhi/mflo read directly.
- `busy` and `start` feed the hazard unit, which stalls any md-class instruction in ID while an operation is pending.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (must be 1..2^CNT_W-1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (must be 1..2^CNT_W-1)
- CNT_W, 4, width of the internal latency counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  EX-stage md instruction valid this cycle
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- rs_data  in  32  forwarded GPR[rs]
- rt_data  in  32  forwarded GPR[rt]
- busy  out  1  a mult/div operation is in flight
- done  out  1  one-cycle pulse: HI/LO just committed by mult/div
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, operand latches=0.
  - Reset mid-operation aborts the operation; no commit occurs.
- States: IDLE, BUSY.
- IDLE:
  - start=1 with md_op in 1..4:
    - latch rs_data, rt_data, md_op.
    - load counter with MULT_CYCLES or DIV_CYCLES.
    - go to BUSY; busy=1 from the following cycle.
  - start=1 with md_op=5 (mthi): hi<=rs_data at that edge; no busy; lo unchanged.
  - start=1 with md_op=6 (mtlo): lo<=rs_data at that edge; no busy; hi unchanged.
  - start=1 with md_op 0 or 7: no effect.
- BUSY:
  - counter decrements each edge.
  - At the edge where counter reaches 0: write hi/lo, go to IDLE.
  - busy=0 and done=1 for exactly one cycle after that edge.
  - Timing: start sampled at edge k → busy high for cycles k+1..k+N, where N = the configured latency. New hi/lo are visible from edge k+N.
- Arithmetic, using latched operands:
  - mult: signed 32x32 → 64-bit product; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 → 64-bit product; hi=[63:32], lo=[31:0].
  - div: signed, quotient truncated toward zero; lo=quotient, hi=remainder; remainder takes the sign of the dividend.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Divide by zero: full DIV_CYCLES latency still taken; hi/lo left unchanged; done still pulses.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0 (wraps, no trap).
- Boundary cases:
  - start=1 while BUSY: ignored; operands and counter untouched. Upstream stall logic must prevent this.
  - hi/lo are not altered during BUSY; mfhi/mflo read the old values until commit.
  - Back-to-back: a start in the cycle done=1 (state IDLE) is accepted normally.

Test Plan:
- Reset then idle: reset low for 3 cycles → busy=0, done=0, hi=0, lo=0; release, hold start=0 for 20 cycles → all outputs unchanged.
- mult signed: rs=0xFFFFFFFE (-2), rt=3, start pulse at edge k → busy=1 for edges k+1..k+5; at k+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle.
- divu then div: divu 7/2 → after 10 busy cycles lo=3, hi=1. Next cycle div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero and overflow:
  - hi=0x11, lo=0x22, then div x/0 → busy 10 cycles, done pulses, hi=0x11, lo=0x22 unchanged.
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi/mtlo and ignored start:
  - mthi rs=0xDEADBEEF → hi updated same edge, busy stays 0.
  - Start multu while BUSY → no effect on operands or count; the first op's result commits on schedule.
- Mid-op reset: start mult, assert reset at busy cycle 3 → busy=0, hi=lo=0 immediately (async); no done pulse after release.
